// File: rtl/pattern_loader.sv
// Game of Life grid seeder: latches a pattern code on start, then writes every
// cell in row-major order, one per clock, and pulses done after the last write.
module pattern_loader #(
   parameter  int ROWS = 16,
   parameter  int COLS = 16,
   localparam int RW   = $clog2(ROWS),
   localparam int CW   = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    pattern_code,
   output logic          busy,
   output logic          done,
   output logic          wr_en,
   output logic [RW-1:0] wr_row,
   output logic [CW-1:0] wr_col,
   output logic          wr_data
);

   // state | meaning
   // IDLE  | waiting for start, outputs quiet
   // WRITE | one cell write per cycle at (row_q, col_q)
   // DONE  | single-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] RC     = RW'(ROWS / 2);
   localparam logic [RW-1:0] RC_P1  = RW'(ROWS / 2 + 1);
   localparam logic [CW-1:0] CC     = CW'(COLS / 2);
   localparam logic [CW-1:0] CC_M1  = CW'(COLS / 2 - 1);
   localparam logic [CW-1:0] CC_P1  = CW'(COLS / 2 + 1);

   state_t        state;
   logic [1:0]    code_q;
   logic [RW-1:0] row_q, row_nxt;
   logic [CW-1:0] col_q, col_nxt;
   logic          last;

   function automatic logic cell_alive(input logic [1:0] code,
                                       input logic [RW-1:0] r,
                                       input logic [CW-1:0] c);
      case (code)
         2'b01:   return (r == RW'(1) && c == CW'(2)) ||
                         (r == RW'(2) && c == CW'(3)) ||
                         (r == RW'(3) && (c == CW'(1) || c == CW'(2) || c == CW'(3)));
         2'b10:   return (r == RC) && (c == CC_M1 || c == CC || c == CC_P1);
         2'b11:   return (r == RC || r == RC_P1) && (c == CC || c == CC_P1);
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      last    = (row_q == R_LAST) && (col_q == C_LAST);
      row_nxt = row_q;
      col_nxt = col_q + CW'(1);
      if (col_q == C_LAST) begin
         col_nxt = '0;
         row_nxt = row_q + RW'(1);
      end
   end

   // Outputs are registers updated alongside the state so nothing combinational
   // reaches a port; wr_data is precomputed for the address being loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         code_q  <= 2'b00;
         row_q   <= '0;
         col_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_en   <= 1'b0;
         wr_data <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state   <= WRITE;
                  code_q  <= pattern_code;
                  row_q   <= '0;
                  col_q   <= '0;
                  busy    <= 1'b1;
                  wr_en   <= 1'b1;
                  wr_data <= cell_alive(pattern_code, '0, '0);
               end
            end
            WRITE: begin
               if (last) begin
                  state   <= DONE;
                  row_q   <= '0;
                  col_q   <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  wr_en   <= 1'b0;
                  wr_data <= 1'b0;
               end else begin
                  row_q   <= row_nxt;
                  col_q   <= col_nxt;
                  wr_data <= cell_alive(code_q, row_nxt, col_nxt);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               wr_en   <= 1'b0;
               wr_data <= 1'b0;
               row_q   <= '0;
               col_q   <= '0;
            end
         endcase
      end
   end

   assign wr_row = row_q;
   assign wr_col = col_q;

endmodule

// File: doc/pattern_loader.md
# pattern_loader

Seeds the Game of Life cell grid with the pattern chosen by the pattern selector. On a start request it latches the 2-bit pattern code and sweeps the whole grid in row-major order, issuing one cell write per clock with the alive/dead value for that cell, then pulses `done`. It sits between the selector's `out_pattern` output and the grid memory's write port, and is the consumer and writer of the selected pattern code.

## Interface
- `ROWS`, 16, grid height in cells; must be ≥ 4.
- `COLS`, 16, grid width in cells; must be ≥ 4.
- `RW`, $clog2(ROWS), row address width (derived; not overridden).
- `CW`, $clog2(COLS), column address width (derived; not overridden).

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request; level sampled each cycle.
- `pattern_code`  in  2  selected pattern: 00 blank, 01 glider, 10 blinker, 11 block.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse after the final write.
- `wr_en`  out  1  grid write strobe.
- `wr_row`  out  RW  row address of the current write.
- `wr_col`  out  CW  column address of the current write.
- `wr_data`  out  1  cell value to write: 1 alive, 0 dead.

## Operation
- FSM states: IDLE, WRITE, DONE. Reset state is IDLE.
- IDLE: if `start`=1, latch `pattern_code` into an internal register, clear row/col counters, go to WRITE. Otherwise stay.
- WRITE: `wr_en`=1 and `busy`=1. `wr_row`/`wr_col` come from the counters. `wr_data` = f(latched code, row, col).
  - If col = COLS-1, col wraps to 0 and row increments. Otherwise col increments.
  - After the write at (ROWS-1, COLS-1), go to DONE.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
- Pattern function (Rc = ROWS/2, Cc = COLS/2, integer division); every cell not listed is 0:
  - 00 blank: all cells dead.
  - 01 glider: (1,2), (2,3), (3,1), (3,2), (3,3).
  - 10 blinker: (Rc,Cc-1), (Rc,Cc), (Rc,Cc+1).
  - 11 block: (Rc,Cc), (Rc,Cc+1), (Rc+1,Cc), (Rc+1,Cc+1).
- Every sweep writes every cell exactly once, dead cells included, so the previous generation is fully overwritten.
- `pattern_code` changes after the start cycle have no effect on the sweep in progress.
- `start` in WRITE or DONE is ignored. It is not queued. A `start` held high across DONE is accepted in the following IDLE cycle.

## Timing
- Reset (async assert, at any time including mid-sweep): state IDLE, counters 0, latched code 00. Outputs: `busy`=0, `done`=0, `wr_en`=0, `wr_row`=0, `wr_col`=0, `wr_data`=0. No `done` is issued for an aborted sweep.
- All outputs are registered (driven from state/counters); there is no combinational path from inputs to outputs.
- Cycle N: `start` sampled high in IDLE.
- Cycles N+1 to N+ROWS·COLS: WRITE. First write is (0,0); last write is (ROWS-1, COLS-1). `wr_en` is continuous, with no gaps.
- Cycle N+ROWS·COLS+1: DONE (`done`=1, `wr_en`=0).
- Cycle N+ROWS·COLS+2: IDLE. This is the earliest cycle in which a new `start` is accepted.
- Outside WRITE: `wr_en`=0, `wr_data`=0, and the addresses hold 0.

## Test plan
- Blank load, 16×16: `pattern_code`=00, start pulse at cycle 0. Expect 256 consecutive writes, all with `wr_data`=0. Expect `done` at cycle 257 and `busy` low from cycle 257.
- Glider: code 01. Capture all writes. Exactly 5 cells are alive: (1,2), (2,3), (3,1), (3,2), (3,3). Addresses are row-major with no repeats and no gaps.
- Blinker and block: code 10 gives live cells (8,7), (8,8), (8,9). Code 11 gives live cells (8,8), (8,9), (9,8), (9,9). Total write count is 256 for each.
- Code change and start during sweep: start with 01. At cycle 50 set code=11 and pulse `start`. The output still matches the glider, exactly one `done` is issued, and no second sweep runs.
- Reset mid-sweep: assert `rst_n`=0 at write 100. All outputs go to 0 immediately. After release, stay idle with no `done`. A new start with 10 produces a full, correct blinker sweep.
- Non-square grid: ROWS=4, COLS=8, code 11. Expect 32 writes, column wrap at col 7, live cells (2,4), (2,5), (3,4), (3,5), and `done` at cycle 33.
